// File: rtl/heat_sample_scheduler_if.sv
// Sensor front-end req/ack channel plus the averager load strobe bus.
interface heat_sample_scheduler_if #(
    parameter int CW     = 2,
    parameter int DATA_W = 11
);
    logic              sens_req;
    logic [CW-1:0]     sens_ch;
    logic              sens_ack;
    logic [DATA_W-1:0] sens_data;
    logic              avg_load;
    logic [CW-1:0]     avg_ch;
    logic [DATA_W-1:0] avg_data;

    modport master (
        output sens_req, sens_ch, avg_load, avg_ch, avg_data,
        input  sens_ack, sens_data
    );

    modport slave (
        input  sens_req, sens_ch, avg_load, avg_ch, avg_data,
        output sens_ack, sens_data
    );
endinterface

// File: rtl/heat_sample_scheduler.sv
// Tick-paced sweep over enabled channels: req/ack per channel, load strobe the cycle after ack.
// Hot alarm comparator only exists when SCHED_HOTALARM_EN is defined.
module heat_sample_scheduler #(
    parameter int                NUM_CH      = 4,
    parameter int                DATA_W      = 11,
    parameter int                TICK_DIV    = 2000000000,
    parameter int                ACK_TIMEOUT = 255,
    parameter logic [DATA_W-1:0] HOT_THRESH  = DATA_W'(600)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [NUM_CH-1:0]       ch_en,
    heat_sample_scheduler_if.master bus,
    output logic                    busy,
    output logic [NUM_CH-1:0]       timeout_err,
    output logic                    overrun_err,
    input  logic                    err_clr,
    output logic                    hot_alarm
);
    localparam int CW = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int WW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT_TICK, REQ, LOAD} state_t;

    state_t              state, state_n;
    logic [TW-1:0]       tick_cnt;
    logic [WW-1:0]       wait_cnt;
    logic [NUM_CH-1:0]   mask;
    logic [CW-1:0]       cur_ch;
    logic [DATA_W-1:0]   data_q;
    logic                tick;
    logic                start, capture, expire, adv;
    logic                first_vld, next_vld;
    logic [CW-1:0]       first_ch, next_ch;

    assign tick = enable && (tick_cnt == TW'(TICK_DIV - 1));

    // Lowest set bit of ch_en for a new sweep, next higher set bit of the latched mask.
    always_comb begin
        first_vld = 1'b0;
        first_ch  = '0;
        next_vld  = 1'b0;
        next_ch   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_en[i]) begin
                first_vld = 1'b1;
                first_ch  = CW'(i);
            end
            if (mask[i] && (i > int'(cur_ch))) begin
                next_vld = 1'b1;
                next_ch  = CW'(i);
            end
        end
    end

    always_comb begin
        state_n = state;
        start   = 1'b0;
        capture = 1'b0;
        expire  = 1'b0;
        adv     = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_n = WAIT_TICK;
            end
            WAIT_TICK: begin
                if (!enable) begin
                    state_n = IDLE;
                end else if (tick) begin
                    start = 1'b1;
                    if (first_vld) state_n = REQ;
                end
            end
            REQ: begin
                // Timeout cycle has sens_req already low, so a late ack is ignored here.
                if (wait_cnt == WW'(ACK_TIMEOUT)) begin
                    expire = 1'b1;
                    adv    = 1'b1;
                end else if (bus.sens_ack) begin
                    capture = 1'b1;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                adv = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        if (adv) begin
            if (enable && next_vld) state_n = REQ;
            else if (enable)        state_n = WAIT_TICK;
            else                    state_n = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            wait_cnt    <= '0;
            mask        <= '0;
            cur_ch      <= '0;
            data_q      <= '0;
            timeout_err <= '0;
            overrun_err <= 1'b0;
        end else begin
            state <= state_n;

            if (!enable || tick) tick_cnt <= '0;
            else                 tick_cnt <= tick_cnt + TW'(1);

            if (state == REQ && !adv && !capture) wait_cnt <= wait_cnt + WW'(1);
            else                                  wait_cnt <= '0;

            if (start) begin
                mask   <= ch_en;
                cur_ch <= first_ch;
            end else if (adv && next_vld) begin
                cur_ch <= next_ch;
            end

            if (capture) data_q <= bus.sens_data;

            // Clear then set, so a new error in the clear cycle survives.
            timeout_err <= (err_clr ? '0 : timeout_err)
                         | ({{(NUM_CH-1){1'b0}}, expire} << cur_ch);
            overrun_err <= (err_clr ? 1'b0 : overrun_err) | (tick && busy);
        end
    end

    assign busy          = (state == REQ) || (state == LOAD);
    assign bus.sens_req  = (state == REQ) && (wait_cnt != WW'(ACK_TIMEOUT));
    assign bus.sens_ch   = cur_ch;
    assign bus.avg_load  = (state == LOAD);
    assign bus.avg_ch    = cur_ch;
    assign bus.avg_data  = data_q;

`ifdef SCHED_HOTALARM_EN
    always_ff @(posedge clk) begin
        if (reset)                                       hot_alarm <= 1'b0;
        else if (state == LOAD && data_q > HOT_THRESH)   hot_alarm <= 1'b1;
        else if (err_clr)                                hot_alarm <= 1'b0;
    end
`else
    logic unused_thresh;
    assign unused_thresh = ^HOT_THRESH;
    assign hot_alarm     = 1'b0;
`endif

endmodule

// File: tb/tb_heat_sample_scheduler.sv
// Directed scoreboard bench: expected loads queued by stimulus, popped by a load monitor.
`timescale 1ns/1ps
module tb_heat_sample_scheduler;
    localparam int CW     = 2;
    localparam int DATA_W = 11;
`ifdef SCHED_HOTALARM_EN
    localparam int HOT_EXP = 1;
`else
    localparam int HOT_EXP = 0;
`endif

    typedef struct {
        int ch;
        int dat;
    } ld_t;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic        enable  = 1'b0;
    logic        err_clr = 1'b0;
    logic [3:0]  ch_en   = 4'b0000;
    logic        busy;
    logic [3:0]  timeout_err;
    logic        overrun_err;
    logic        hot_alarm;

    heat_sample_scheduler_if #(.CW(CW), .DATA_W(DATA_W)) bus();

    heat_sample_scheduler #(
        .NUM_CH(4), .DATA_W(DATA_W), .TICK_DIV(10), .ACK_TIMEOUT(5)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .ch_en(ch_en),
        .bus(bus.master), .busy(busy), .timeout_err(timeout_err),
        .overrun_err(overrun_err), .err_clr(err_clr), .hot_alarm(hot_alarm)
    );

    always #5 clk = ~clk;

    int  n_checks = 0;
    int  n_pass   = 0;
    ld_t exp_q[$];
    int  req_cnt[4];
    int  last_len[4];

    int          ack_delay = 2;
    logic [3:0]  noack     = 4'b0000;
    logic [10:0] dat_tab [4];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    endtask

    task automatic push_ld(input int ch, input int d);
        ld_t e;
        e.ch  = ch;
        e.dat = d;
        exp_q.push_back(e);
    endtask

    function automatic int req_mask(input int s[4]);
        int m = 0;
        for (int i = 0; i < 4; i++) if (req_cnt[i] != s[i]) m |= (1 << i);
        return m;
    endfunction

    function automatic int req_delta(input int s[4]);
        int d = 0;
        for (int i = 0; i < 4; i++) d += req_cnt[i] - s[i];
        return d;
    endfunction

    task automatic wait_busy(input logic lvl, input int lim, input string nm);
        int k = 0;
        while (busy !== lvl && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk(nm, int'(busy === lvl), 1);
    endtask

    task automatic wait_req(input int ch, input int lim, input string nm);
        int k = 0;
        while (!(bus.sens_req === 1'b1 && int'(bus.sens_ch) == ch) && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk(nm, int'(bus.sens_req === 1'b1 && int'(bus.sens_ch) == ch), 1);
    endtask

    task automatic wait_load(input int lim, input string nm);
        int k = 0;
        while (bus.avg_load !== 1'b1 && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk(nm, int'(bus.avg_load === 1'b1), 1);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        enable  = 1'b0;
        err_clr = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Sensor model: ack for one cycle ack_delay negedges into a request, unless muted.
    initial begin
        int w = 0;
        bus.sens_ack  = 1'b0;
        bus.sens_data = '0;
        forever begin
            @(negedge clk);
            if (bus.sens_req) begin
                w++;
                if (w == ack_delay && !noack[bus.sens_ch]) begin
                    bus.sens_ack  = 1'b1;
                    bus.sens_data = dat_tab[bus.sens_ch];
                end else begin
                    bus.sens_ack = 1'b0;
                end
            end else begin
                w = 0;
                bus.sens_ack = 1'b0;
            end
        end
    end

    // Load monitor and request statistics.
    initial begin
        logic       prev_req = 1'b0;
        logic [1:0] prev_ch  = 2'd0;
        int         run      = 0;
        ld_t        e;
        forever begin
            @(negedge clk);
            if (bus.avg_load === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_load: got ch%0d data %0d, required no load",
                             bus.avg_ch, bus.avg_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("load_ch", int'(bus.avg_ch), e.ch);
                    chk("load_data", int'(bus.avg_data), e.dat);
                end
            end
            if (bus.sens_req && !prev_req) begin
                req_cnt[bus.sens_ch]++;
                run = 1;
            end else if (bus.sens_req) begin
                run++;
            end else if (prev_req) begin
                last_len[prev_ch] = run;
            end
            prev_req = bus.sens_req;
            prev_ch  = bus.sens_ch;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap[4];
        int n;

        // Reset state while reset is held
        repeat (3) @(negedge clk);
        chk("rst_sens_req", int'(bus.sens_req), 0);
        chk("rst_avg_load", int'(bus.avg_load), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_timeout_err", int'(timeout_err), 0);
        chk("rst_overrun_err", int'(overrun_err), 0);
        chk("rst_hot_alarm", int'(hot_alarm), 0);

        // 1: mask 1011, ch2 skipped; mid-sweep ch_en change must not matter
        do_reset();
        dat_tab = '{11'd100, 11'd200, 11'd0, 11'd300};
        noack = 4'b0000;
        push_ld(0, 100);
        push_ld(1, 200);
        push_ld(3, 300);
        snap = req_cnt;
        ch_en = 4'b1011;
        enable = 1'b1;
        wait_busy(1'b1, 30, "t1_sweep_start");
        ch_en = 4'b0111;
        wait_busy(1'b0, 40, "t1_sweep_end");
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("t1_req_mask", req_mask(snap), 4'b1011);
        chk("t1_overrun_err", int'(overrun_err), 0);
        chk("t1_timeout_err", int'(timeout_err), 0);
        chk("t1_queue_drained", exp_q.size(), 0);

        // 2: ch1 never acks -> 5-cycle request, timeout flag, sweep continues to ch2
        do_reset();
        dat_tab = '{11'd10, 11'd20, 11'd30, 11'd40};
        noack = 4'b0010;
        push_ld(2, 30);
        snap = req_cnt;
        ch_en = 4'b0110;
        enable = 1'b1;
        wait_busy(1'b1, 30, "t2_sweep_start");
        wait_busy(1'b0, 40, "t2_sweep_end");
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("t2_timeout_err", int'(timeout_err), 4'b0010);
        chk("t2_ch1_req_len", last_len[1], 5);
        chk("t2_req_mask", req_mask(snap), 4'b0110);
        chk("t2_overrun_err", int'(overrun_err), 0);
        chk("t2_queue_drained", exp_q.size(), 0);

        // 3: no acks on 4 channels -> sweep outlasts a tick, overrun set, no restart
        do_reset();
        noack = 4'b1111;
        snap = req_cnt;
        ch_en = 4'b1111;
        enable = 1'b1;
        wait_busy(1'b1, 30, "t3_sweep_start");
        wait_busy(1'b0, 60, "t3_sweep_end");
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("t3_overrun_err", int'(overrun_err), 1);
        chk("t3_req_count", req_delta(snap), 4);
        chk("t3_timeout_err", int'(timeout_err), 4'b1111);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("t3_overrun_cleared", int'(overrun_err), 0);
        chk("t3_timeout_cleared", int'(timeout_err), 0);

        // 4: reset mid-request on ch1, then first request in the 11th cycle after release
        do_reset();
        noack = 4'b1111;
        ch_en = 4'b0011;
        enable = 1'b1;
        wait_req(1, 40, "t4_reach_ch1");
        @(negedge clk);
        chk("t4_pre_timeout_err", int'(timeout_err), 4'b0001);
        reset = 1'b1;
        @(negedge clk);
        chk("t4_sens_req", int'(bus.sens_req), 0);
        chk("t4_busy", int'(busy), 0);
        chk("t4_timeout_err", int'(timeout_err), 0);
        chk("t4_overrun_err", int'(overrun_err), 0);
        reset = 1'b0;
        n = 0;
        while (!bus.sens_req && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("t4_first_req_cycle", n, 10);
        enable = 1'b0;
        wait_busy(1'b0, 20, "t4_drain");

        // 5: enable dropped during ch0 request -> only ch0 loads, then idle
        do_reset();
        dat_tab = '{11'd55, 11'd66, 11'd77, 11'd88};
        noack = 4'b0000;
        push_ld(0, 55);
        snap = req_cnt;
        ch_en = 4'b1111;
        enable = 1'b1;
        wait_req(0, 30, "t5_req_ch0");
        enable = 1'b0;
        wait_busy(1'b0, 20, "t5_sweep_end");
        repeat (15) @(negedge clk);
        chk("t5_busy", int'(busy), 0);
        chk("t5_req_count", req_delta(snap), 1);
        chk("t5_queue_drained", exp_q.size(), 0);

        // 6: 601 then 599 against threshold 600
        do_reset();
        dat_tab = '{11'd601, 11'd599, 11'd0, 11'd0};
        push_ld(0, 601);
        push_ld(1, 599);
        ch_en = 4'b0011;
        enable = 1'b1;
        wait_load(30, "t6_first_load");
        @(negedge clk);
        chk("t6_hot_after_601", int'(hot_alarm), HOT_EXP);
        wait_busy(1'b0, 20, "t6_sweep_end");
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_hot_after_599", int'(hot_alarm), HOT_EXP);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("t6_hot_cleared", int'(hot_alarm), 0);
        chk("t6_queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
